// File: rtl/spm_pkg.sv
// spm_pkg: shared types and sizing helpers for the serial-parallel multiplier.
package spm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return $clog2(2 * w) + 1;
  endfunction
endpackage

// File: rtl/spm_csa_cell.sv
// spm_csa_cell: one carry-save bit cell; adds a + b + its own registered carry.
module spm_csa_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s_o,
  output logic s_q_o
);
  logic s_q, c_q, c_d;
  assign s_o = a ^ b ^ c_q;
  assign c_d = (a & b) | (a & c_q) | (b & c_q);
  assign s_q_o = s_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s_q, c_q} <= 2'b00;
    else if (clr) {s_q, c_q} <= 2'b00;
    else if (en) {s_q, c_q} <= {s_o, c_d};
endmodule

// File: rtl/serial_parallel_mult.sv
// serial_parallel_mult: unsigned SPM, y fed LSB first into WIDTH carry-save cells.
// Define SPM_BUSY_EN to add a busy port and expose the live product during RUN.
module serial_parallel_mult
  import spm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SPM_BUSY_EN
  output logic               busy,
`endif
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               done,
  output logic [2*WIDTH-1:0] fullprod
);
  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;
  state_e state_q, state_d;
  logic [WIDTH-1:0] xr_q, yr_q, s_c, s_r, s_in;
  logic [CW-1:0] k_q;
  logic [PW-1:0] prod_q, yext;
  logic ybit, cap, run;
  assign cap = state_q == IDLE;
  assign run = state_q == RUN;
  // past WIDTH the zero-extended operand supplies the flush zeros
  assign yext = PW'(yr_q);
  assign ybit = yext[k_q[CW-2:0]];
  assign s_in = {1'b0, s_r[WIDTH-1:1]};
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    spm_csa_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .clr  (cap),
      .en   (run),
      .a    (xr_q[i] & ybit),
      .b    (s_in[i]),
      .s_o  (s_c[i]),
      .s_q_o(s_r[i])
    );
  end
  always_comb
    state_d = cap ? RUN :
              run ? (k_q == CW'(PW - 1) ? DONE : RUN) :
              ((x != xr_q || y != yr_q) ? IDLE : DONE);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      k_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cap) begin
        xr_q   <= x;
        yr_q   <= y;
        k_q    <= '0;
        prod_q <= '0;
      end else if (run) begin
        k_q    <= k_q + 1'b1;
        prod_q <= {s_c[0], prod_q[PW-1:1]};
      end
    end
  assign done = state_q == DONE;
`ifdef SPM_BUSY_EN
  assign busy = run;
  assign fullprod = (done || run) ? prod_q : '0;
`else
  assign fullprod = done ? prod_q : '0;
`endif
endmodule

// File: tb/tb_serial_parallel_mult.sv
// tb_serial_parallel_mult: scoreboard bench; expected products queued when operands are driven.
module tb_serial_parallel_mult;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic done;
  logic [15:0] fullprod;
`ifdef SPM_BUSY_EN
  logic busy;
`endif
  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  serial_parallel_mult #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef SPM_BUSY_EN
    .busy    (busy),
`endif
    .x       (x),
    .y       (y),
    .done    (done),
    .fullprod(fullprod)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    int b = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
`ifdef SPM_BUSY_EN
      if (busy) b++;
`endif
      if (done) begin
        n = i;
        break;
      end
    end
    check({tag, "_latency"}, n, 17);
`ifdef SPM_BUSY_EN
    check({tag, "_busy"}, b, 16);
`endif
    if (sb.size() == 0) check({tag, "_sb_empty"}, 1, 0);
    else check({tag, "_prod"}, fullprod, sb.pop_front());
  endtask

  task automatic apply(input logic [7:0] xv, input logic [7:0] yv, input logic [15:0] exp, input string tag);
    @(negedge clk);
    x = xv;
    y = yv;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    check({tag, "_drop"}, done, 0);
    wait_result(tag);
  endtask

  initial begin
    logic [7:0] xv, yv;
    repeat (2) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_prod", fullprod, 16'h0000);
    check("rst_x", 32'($isunknown({done, fullprod})), 0);
    x = 8'h0D;
    y = 8'h27;
    sb.push_back(16'h01FB);
    rst = 1'b1;
    wait_result("first");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_done", done, 1);
      check("hold_prod", fullprod, 16'h01FB);
    end
    apply(8'h0D, 8'h03, 16'h0027, "chg_y");
    apply(8'hFF, 8'hFF, 16'hFE01, "ones");
    apply(8'h00, 8'hA5, 16'h0000, "xzero");
    apply(8'h01, 8'h80, 16'h0080, "msb");
    apply(8'hA5, 8'h00, 16'h0000, "yzero");
    // abort a run partway through RUN
    @(negedge clk);
    x = 8'h5A;
    y = 8'hC3;
    sb.push_back(16'h448E);
    repeat (7) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrun_done", done, 0);
    check("midrun_prod", fullprod, 0);
`ifdef SPM_BUSY_EN
    check("midrun_busy", busy, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    wait_result("after_midrun");
    // reset in DONE must clear outputs before any further clock edge
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_done", done, 0);
    check("async_prod", fullprod, 0);
    @(negedge clk);
    x = 8'h12;
    y = 8'h34;
    sb.push_back(16'h03A8);
    rst = 1'b1;
    wait_result("after_async");
    for (int i = 0; i < 200; i++) begin
      xv = 8'($urandom_range(0, 255));
      yv = 8'($urandom_range(0, 255));
      if (xv == x && yv == y) yv = yv ^ 8'h01;
      apply(xv, yv, 16'(xv) * 16'(yv), "rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
